pe_array_sequencer: RTL and testbench

- Driver side of the 4x4 systolic PE array. The sequencer sits between the on-chip buffers and the array.
- Serially streams 16 weights into the array with a load-weight strobe.
- Launches one activation vector per job with per-column skew, injects per-row initial psums with per-row skew, then captures the skewed psum outputs and presents them as one deskewed result vector over valid/ready.

---
 rtl/pe_array_sequencer.sv | 131 +++++++++++++
 tb/tb_pe_array_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: drives a 4x4 systolic PE array -- serial weight load, skewed
// activation/psum launch, and deskewed capture of the row psum outputs.
module pe_array_sequencer #(
    parameter int ACT_W    = 9,
    parameter int PSUM_W   = 13,
    parameter int PSUM_LAT = 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                wgt_valid_in,
    output logic                wgt_ready_out,
    input  logic [ACT_W-1:0]    wgt_data_in,
    input  logic                act_valid_in,
    output logic                act_ready_out,
    input  logic [4*ACT_W-1:0]  act_vec_in,
    input  logic [4*PSUM_W-1:0] psum_init_in,
    output logic                res_valid_out,
    input  logic                res_ready_in,
    output logic [4*PSUM_W-1:0] res_vec_out,
    output logic                load_weight_out,
    output logic [ACT_W-1:0]    weight_out,
    output logic [ACT_W-1:0]    activation_column_0_out,
    output logic [ACT_W-1:0]    activation_column_1_out,
    output logic [ACT_W-1:0]    activation_column_2_out,
    output logic [ACT_W-1:0]    activation_column_3_out,
    output logic [PSUM_W-1:0]   psum_row_0_out,
    output logic [PSUM_W-1:0]   psum_row_1_out,
    output logic [PSUM_W-1:0]   psum_row_2_out,
    output logic [PSUM_W-1:0]   psum_row_3_out,
    input  logic [PSUM_W-1:0]   psum_row_0_in,
    input  logic [PSUM_W-1:0]   psum_row_1_in,
    input  logic [PSUM_W-1:0]   psum_row_2_in,
    input  logic [PSUM_W-1:0]   psum_row_3_in
);
    localparam int TW = $clog2(PSUM_LAT + 10);
    localparam logic [TW-1:0] T_END = TW'(8 + PSUM_LAT);
    localparam int HOLD = 7 + PSUM_LAT;

    typedef enum logic [1:0] {IDLE, LOADW, FEED, OUT} state_t;

    state_t             state, state_nx;
    logic               weights_loaded, act_rdy_q, wgt_fire, act_fire;
    logic [3:0]         wcnt;
    logic [TW-1:0]      t, nt;
    logic [ACT_W-1:0]   act [4];
    logic [ACT_W-1:0]   act_src [4];
    logic [ACT_W-1:0]   col [4];
    logic [PSUM_W-1:0]  init [4];
    logic [PSUM_W-1:0]  init_src [4];
    logic [PSUM_W-1:0]  prow [4];
    logic [PSUM_W-1:0]  pin [4];

    assign pin[0] = psum_row_0_in;
    assign pin[1] = psum_row_1_in;
    assign pin[2] = psum_row_2_in;
    assign pin[3] = psum_row_3_in;
    assign activation_column_0_out = col[0];
    assign activation_column_1_out = col[1];
    assign activation_column_2_out = col[2];
    assign activation_column_3_out = col[3];
    assign psum_row_0_out = prow[0];
    assign psum_row_1_out = prow[1];
    assign psum_row_2_out = prow[2];
    assign psum_row_3_out = prow[3];

    // A same-cycle weight beat must win, so the registered ready is masked by wgt_valid_in
    assign act_ready_out = act_rdy_q & ~wgt_valid_in;
    assign wgt_fire      = wgt_valid_in & wgt_ready_out;
    assign act_fire      = act_valid_in & act_ready_out;
    assign nt            = (state == FEED) ? t + 1'b1 : '0;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            act_src[i]  = act_fire ? act_vec_in[i*ACT_W +: ACT_W] : act[i];
            init_src[i] = act_fire ? psum_init_in[i*PSUM_W +: PSUM_W] : init[i];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = wgt_fire ? LOADW : act_fire ? FEED : IDLE;
            LOADW:   state_nx = (wgt_fire && wcnt == 4'd15) ? IDLE : LOADW;
            FEED:    state_nx = (t == T_END) ? OUT : FEED;
            OUT:     state_nx = res_ready_in ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are computed from the next state/time so they are valid in the cycle they describe
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= IDLE;
            weights_loaded  <= 1'b0;
            wcnt            <= '0;
            t               <= '0;
            act_rdy_q       <= 1'b0;
            wgt_ready_out   <= 1'b0;
            res_valid_out   <= 1'b0;
            load_weight_out <= 1'b0;
            weight_out      <= '0;
            res_vec_out     <= '0;
            for (int i = 0; i < 4; i++) begin
                act[i]  <= '0;
                init[i] <= '0;
                col[i]  <= '0;
                prow[i] <= '0;
            end
        end else begin
            state           <= state_nx;
            t               <= nt;
            wgt_ready_out   <= state_nx == IDLE || state_nx == LOADW;
            act_rdy_q       <= state_nx == IDLE && (wgt_fire ? wcnt == 4'd15 : weights_loaded);
            res_valid_out   <= state_nx == OUT;
            load_weight_out <= wgt_fire;
            if (wgt_fire) begin
                weight_out     <= wgt_data_in;
                wcnt           <= wcnt + 4'd1;
                weights_loaded <= wcnt == 4'd15;
            end
            for (int i = 0; i < 4; i++) begin
                act[i]  <= act_src[i];
                init[i] <= init_src[i];
                col[i]  <= (state_nx == FEED && nt >= TW'(i) && nt <= TW'(HOLD)) ? act_src[i] : '0;
                prow[i] <= (state_nx == FEED && nt >= TW'(4 + i) && nt <= TW'(HOLD)) ? init_src[i] : '0;
                if (state == FEED && t == TW'(4 + i + PSUM_LAT))
                    res_vec_out[i*PSUM_W +: PSUM_W] <= pin[i];
            end
        end
    end
endmodule

// File: tb/tb_pe_array_sequencer.sv
// tb_pe_array_sequencer: directed + randomized checks of the PE array sequencer
// against a timing/result model built from the array's skew rules.
module tb_pe_array_sequencer;
    localparam int ACT_W = 9, PSUM_W = 13, AW4 = 4 * ACT_W, PW4 = 4 * PSUM_W;

    logic clk_in = 0, rst_in = 0;
    logic wgt_valid_in = 0, act_valid_in = 0, res_ready_in = 0;
    logic [ACT_W-1:0] wgt_data_in = '0;
    logic [AW4-1:0] act_vec_in = '0;
    logic [PW4-1:0] psum_init_in = '0;
    logic wgt_ready_out, act_ready_out, res_valid_out, load_weight_out;
    logic [PW4-1:0] res_vec_out;
    logic [ACT_W-1:0] weight_out, c0, c1, c2, c3;
    logic [PSUM_W-1:0] po0, po1, po2, po3, pi0, pi1, pi2, pi3;

    int n_tests = 0, n_fail = 0;
    logic [ACT_W-1:0] wq [16];
    logic [ACT_W-1:0] ja [4];
    logic [PSUM_W-1:0] ji [4];
    logic [AW4+PW4-1:0] drives;
    logic [159:0] all_outs;

    pe_array_sequencer dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .wgt_valid_in(wgt_valid_in), .wgt_ready_out(wgt_ready_out), .wgt_data_in(wgt_data_in),
        .act_valid_in(act_valid_in), .act_ready_out(act_ready_out), .act_vec_in(act_vec_in),
        .psum_init_in(psum_init_in),
        .res_valid_out(res_valid_out), .res_ready_in(res_ready_in), .res_vec_out(res_vec_out),
        .load_weight_out(load_weight_out), .weight_out(weight_out),
        .activation_column_0_out(c0), .activation_column_1_out(c1),
        .activation_column_2_out(c2), .activation_column_3_out(c3),
        .psum_row_0_out(po0), .psum_row_1_out(po1), .psum_row_2_out(po2), .psum_row_3_out(po3),
        .psum_row_0_in(pi0), .psum_row_1_in(pi1), .psum_row_2_in(pi2), .psum_row_3_in(pi3)
    );

    always #5 clk_in = ~clk_in;

    // Array stand-in: each row output is its input plus 100*(row+1), one cycle later
    always_ff @(posedge clk_in) begin
        pi0 <= po0 + PSUM_W'(100);
        pi1 <= po1 + PSUM_W'(200);
        pi2 <= po2 + PSUM_W'(300);
        pi3 <= po3 + PSUM_W'(400);
    end

    assign drives = {c3, c2, c1, c0, po3, po2, po1, po0};
    assign all_outs = 160'({wgt_ready_out, act_ready_out, res_valid_out, load_weight_out,
                            weight_out, res_vec_out, drives});

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic refuse(input int n);
        act_valid_in = 1;
        for (int i = 0; i < n; i++) begin
            step();
            chk("refuse_act_ready", 160'(act_ready_out), 160'(0));
            chk("refuse_drives", 160'(drives), 160'(0));
        end
        act_valid_in = 0;
    endtask

    task automatic load_weights(input int gap_at, input bit with_act);
        chk("wgt_ready_idle", 160'(wgt_ready_out), 160'(1));
        for (int i = 0; i < 16; i++) begin
            wgt_valid_in = 1;
            wgt_data_in = wq[i];
            if (i == 0 && with_act) begin
                act_valid_in = 1;
                #1;
                chk("wgt_priority_act_ready", 160'(act_ready_out), 160'(0));
            end
            step();
            act_valid_in = 0;
            chk("load_pulse", 160'(load_weight_out), 160'(1));
            chk("weight_out", 160'(weight_out), 160'(wq[i]));
            if (i == gap_at) begin
                wgt_valid_in = 0;
                for (int g = 0; g < 2; g++) begin
                    step();
                    chk("gap_no_pulse", 160'(load_weight_out), 160'(0));
                    chk("gap_weight_hold", 160'(weight_out), 160'(wq[i]));
                    chk("gap_act_ready", 160'(act_ready_out), 160'(0));
                    chk("gap_wgt_ready", 160'(wgt_ready_out), 160'(1));
                end
            end
        end
        wgt_valid_in = 0;
        #1;
        chk("loaded_act_ready", 160'(act_ready_out), 160'(1));
        step();
        chk("load_pulse_end", 160'(load_weight_out), 160'(0));
    endtask

    task automatic run_job(input int hold);
        logic [AW4+PW4-1:0] exp_d;
        logic [PW4-1:0] exp_r;
        int n = 0;
        for (int r = 0; r < 4; r++) begin
            act_vec_in[r*ACT_W +: ACT_W] = ja[r];
            psum_init_in[r*PSUM_W +: PSUM_W] = ji[r];
            exp_r[r*PSUM_W +: PSUM_W] = ji[r] + PSUM_W'(100 * (r + 1));
        end
        act_valid_in = 1;
        while (!act_ready_out && n < 20) begin
            step();
            n++;
        end
        chk("job_ready", 160'(act_ready_out), 160'(1));
        step();
        act_valid_in = 0;
        act_vec_in = AW4'({$urandom(), $urandom()});
        psum_init_in = PW4'({$urandom(), $urandom()});
        // k = cycles since the handshake edge = FEED time t while t <= 9
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) step();
            if (k <= 8) begin
                exp_d = '0;
                for (int c = 0; c < 4; c++)
                    if (k >= c) exp_d[PW4 + c*ACT_W +: ACT_W] = ja[c];
                for (int r = 0; r < 4; r++)
                    if (k >= 4 + r) exp_d[r*PSUM_W +: PSUM_W] = ji[r];
                chk($sformatf("drives_t%0d", k), 160'(drives), 160'(exp_d));
            end
            if (k < 10) begin
                chk("res_valid_early", 160'(res_valid_out), 160'(0));
                chk("busy_readies", 160'({wgt_ready_out, act_ready_out}), 160'(0));
            end
        end
        chk("res_valid_lat10", 160'(res_valid_out), 160'(1));
        chk("res_vec", 160'(res_vec_out), 160'(exp_r));
        chk("out_drives_zero", 160'(drives), 160'(0));
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", 160'(res_valid_out), 160'(1));
            chk("hold_vec", 160'(res_vec_out), 160'(exp_r));
        end
        res_ready_in = 1;
        step();
        res_ready_in = 0;
        chk("res_valid_drop", 160'(res_valid_out), 160'(0));
        chk("act_ready_back", 160'(act_ready_out), 160'(1));
    endtask

    task automatic rand_job(input int hold);
        for (int i = 0; i < 4; i++) begin
            ja[i] = ACT_W'($urandom());
            ji[i] = PSUM_W'($urandom());
        end
        run_job(hold);
    endtask

    task automatic rand_weights(input int gap_at);
        for (int i = 0; i < 16; i++) wq[i] = ACT_W'($urandom());
        load_weights(gap_at, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step();
        chk("reset_outputs", all_outs, 160'(0));
        #2 rst_in = 1;
        refuse(20);

        for (int i = 0; i < 16; i++) wq[i] = ACT_W'(i + 1);
        load_weights(-1, 0);

        ja = '{1, 2, 3, 4};
        ji = '{0, 0, 0, 0};
        run_job(0);
        ji = '{5, 6, 7, 8};
        run_job(5);

        load_weights(4, 1);
        for (int j = 0; j < 3; j++) rand_job(j * 2);
        rand_weights(-1);
        rand_job(1);

        // Abort at FEED t=3
        rand_weights(9);
        for (int i = 0; i < 4; i++) begin
            ja[i] = ACT_W'($urandom());
            ji[i] = PSUM_W'($urandom());
            act_vec_in[i*ACT_W +: ACT_W] = ja[i];
            psum_init_in[i*PSUM_W +: PSUM_W] = ji[i];
        end
        act_valid_in = 1;
        step();
        act_valid_in = 0;
        for (int i = 0; i < 3; i++) step();
        chk("pre_abort_col3", 160'(c3), 160'(ja[3]));
        rst_in = 0;
        #1;
        chk("async_reset_outs", all_outs, 160'(0));
        step();
        chk("reset_held_outs", all_outs, 160'(0));
        rst_in = 1;
        refuse(6);
        rand_weights(-1);
        rand_job(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
